// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline-stage register for the inter-stage boundaries
//   (IF/ID, ID/MEX, MEX/WB). Moves a data payload and a control payload
//   downstream under a valid/ready handshake. With SKID=1 a second (skid)
//   register absorbs the beat that arrives in the cycle downstream stalls,
//   so up_ready can be a plain register. With SKID=0 a single register is
//   used and up_ready depends combinationally on dn_ready.
//   A flush kills all contents and leaves zeroed control payloads behind.
//   A saturating counter records cycles in which downstream stalls a beat.
//
// Ports
//   clock        : clock, all state updates on posedge
//   reset_n      : asynchronous active-low reset
//   flush        : synchronous kill of all stage contents (highest priority)
//   up_valid     : upstream beat present
//   up_ready     : stage can accept a beat this cycle
//   up_data      : upstream data payload   [DATA_W]
//   up_ctrl      : upstream control payload [CTRL_W]
//   dn_valid     : beat presented to downstream
//   dn_ready     : downstream accepts the beat
//   dn_data      : downstream data payload  [DATA_W]
//   dn_ctrl      : downstream control payload, 0 whenever dn_valid=0
//   occupancy    : beats held (0, 1, or 2 with SKID=1)
//   stall_cycles : saturating count of dn_valid && !dn_ready cycles [CNT_W]
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 16,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Main register M feeds the outputs; skid register S holds the beat that
  // arrived while M was stalled. S is never visible downstream directly.
  logic [DATA_W-1:0] m_data_p1, s_data_p1;
  logic [CTRL_W-1:0] m_ctrl_p1, s_ctrl_p1;
  logic              rdy_q;
  logic [CNT_W-1:0]  stall_q;

  logic accept, pop;
  logic ld_m_up, ld_m_s, ld_s_up;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign dn_valid = (state_q != ST_EMPTY);
  assign accept   = up_valid && up_ready;
  assign pop      = dn_valid && dn_ready;

  // rdy_q is 0 during reset and rises on the first edge after release.
  // With SKID=0 it only gates the combinational ready out of reset, since
  // the SKID state is unreachable (accept in FULL implies pop).
  assign up_ready = (SKID != 0) ? rdy_q : (rdy_q && (!dn_valid || dn_ready));

  always_comb begin
    state_d = state_q;
    ld_m_up = 1'b0;
    ld_m_s  = 1'b0;
    ld_s_up = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            ld_m_up = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && pop) begin
            ld_m_up = 1'b1;
          end else if (accept) begin
            state_d = ST_SKID;
            ld_s_up = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (pop) begin
            state_d = ST_FULL;
            ld_m_s  = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ---- stage boundary: control state ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_SKID);
      if (dn_valid && !dn_ready) begin
        stall_q <= sat_inc(stall_q);
      end
    end
  end

  // ---- stage boundary: payload registers ----
  // Control payloads are zeroed on flush so a killed beat can never leak
  // enable bits; data payloads only clear when CLR_DATA is set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_data_p1 <= '0;
      m_ctrl_p1 <= '0;
      s_data_p1 <= '0;
      s_ctrl_p1 <= '0;
    end else if (flush) begin
      m_ctrl_p1 <= '0;
      s_ctrl_p1 <= '0;
      if (CLR_DATA != 0) begin
        m_data_p1 <= '0;
        s_data_p1 <= '0;
      end
    end else begin
      if (ld_m_up) begin
        m_data_p1 <= up_data;
        m_ctrl_p1 <= up_ctrl;
      end else if (ld_m_s) begin
        m_data_p1 <= s_data_p1;
        m_ctrl_p1 <= s_ctrl_p1;
      end
      if (ld_s_up) begin
        s_data_p1 <= up_data;
        s_ctrl_p1 <= up_ctrl;
      end
    end
  end

  assign dn_data      = m_data_p1;
  assign dn_ctrl      = dn_valid ? m_ctrl_p1 : '0;
  assign stall_cycles = stall_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
